// File: rtl/mult_div_unit_if.sv
// Bus between the control FSM and the multiply/divide unit.
// Handshake: the master raises start for one cycle with op/a/b valid; the unit
// accepts it only while idle (busy=0, done=0) and ignores it otherwise. busy
// stays high while the operation runs; done pulses for one cycle when hi/lo
// carry the new result (together with div_zero on a trapped divide by zero).
interface mult_div_unit_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;
  logic [2:0]       state_dbg;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, div_zero, state_dbg
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, div_zero, state_dbg
  );
endinterface

// File: rtl/mult_div_unit.sv
// Sequential multiply/divide unit: MULT, MULTU, DIV, DIVU on WIDTH-bit operands,
// one result bit per cycle, double-width result held in hi/lo.
// Shift-add multiply on a 2*WIDTH accumulator, restoring divide with a
// (WIDTH+1)-bit partial remainder; signed ops work on magnitudes and fix the
// signs at the end.
// Optional macro MULTDIV_DIVZERO_EXC_EN: a divide by zero skips the arithmetic,
// pulses done together with div_zero and leaves hi/lo untouched.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic            clock,
  input  logic            reset,
  mult_div_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             state;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q;       // raw a, then |a| (multiplicand)
  logic [WIDTH-1:0]   b_q;       // raw b, then |b| (divisor)
  logic               sign_a;
  logic               sign_b;
  logic [2*WIDTH-1:0] acc;       // product, or dividend/quotient in the low half
  logic [WIDTH-1:0]   rem;
  logic [CW-1:0]      cnt;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               is_div;
  logic               is_signed;
  logic               neg_res;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     shifted;
  logic               no_borrow;
  logic [WIDTH-1:0]   rem_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];
  assign neg_res   = sign_a ^ sign_b;

  // Two's-complement magnitude; -(most negative) lands on 2^(WIDTH-1) unsigned.
  assign mag_a = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
  assign mag_b = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

  // Multiply step: add multiplicand into the upper half when the low bit is set,
  // keep the carry, shift the whole accumulator right by one.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Restoring divide step: bring in the next dividend bit, subtract when it fits.
  assign shifted   = {rem, acc[WIDTH-1]};
  assign no_borrow = shifted[WIDTH] || (shifted[WIDTH-1:0] >= b_q);
  assign rem_next  = no_borrow ? (shifted[WIDTH-1:0] - b_q) : shifted[WIDTH-1:0];

  // Sign correction: product/quotient negative when signs differ, remainder
  // follows the dividend.
  assign prod_fix = neg_res ? -acc : acc;
  assign quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = sign_a ? -rem : rem;

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.state_dbg = state;

`ifdef MULTDIV_DIVZERO_EXC_EN
  logic dz_q;
  assign bus.div_zero = dz_q;
`else
  assign bus.div_zero = 1'b0;
`endif

  // Control FSM and datapath registers; all outputs are registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      acc    <= '0;
      rem    <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
`ifdef MULTDIV_DIVZERO_EXC_EN
      dz_q   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            op_q <= bus.op;
            a_q  <= bus.a;
            b_q  <= bus.b;
`ifdef MULTDIV_DIVZERO_EXC_EN
            if (bus.op[1] && (bus.b == '0)) begin
              state  <= S_DONE;
              done_q <= 1'b1;
              dz_q   <= 1'b1;
            end else
`endif
            begin
              state  <= S_PREP;
              busy_q <= 1'b1;
            end
          end
        end
        S_PREP: begin
          a_q    <= mag_a;
          b_q    <= mag_b;
          sign_a <= is_signed & a_q[WIDTH-1];
          sign_b <= is_signed & b_q[WIDTH-1];
          acc    <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
          rem    <= '0;
          cnt    <= CW'(WIDTH);
          state  <= S_RUN;
        end
        S_RUN: begin
          if (is_div) begin
            rem            <= rem_next;
            acc[WIDTH-1:0] <= {acc[WIDTH-2:0], no_borrow};
          end else begin
            acc <= mul_next;
          end
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          if (is_div) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: begin
          done_q <= 1'b0;
`ifdef MULTDIV_DIVZERO_EXC_EN
          dz_q   <= 1'b0;
`endif
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
